// File: rtl/plot_sink_pkg.sv
// plot_sink_pkg: screen constants shared by plot_sink and the drawers,
// plus the plot-sink drain-state encoding.
package plot_sink_pkg;

  localparam int unsigned COLOR_DEPTH = 9;
  localparam int unsigned SCREEN_W    = 160;
  localparam int unsigned SCREEN_H    = 120;
  localparam int unsigned FB_ADDR_W   = 15;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_DRAIN = 1'b1
  } drain_state_e;

endpackage

// File: rtl/pixel_fifo.sv
// pixel_fifo: synchronous first-word-fall-through FIFO for plot entries.
// Ports:
//   clock, reset   : clock and synchronous active-high reset
//   push, wdata    : write side; a push while full is ignored
//   pop, rdata     : read side; rdata shows the head whenever !empty
//   full, empty    : occupancy flags from registered pointers
module pixel_fifo #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; the pointers alone define valid contents.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/plot_sink.sv
// plot_sink: receives pixel plots from the drawers, clips off-screen
// coordinates, linearises (x, y) into a framebuffer address, buffers the
// result in pixel_fifo and drains it into the framebuffer write port
// whenever fb_grant is high.
// Ports:
//   clock, reset          : clock and synchronous active-high reset
//   plot, x, y, color     : one-cycle pixel write request
//   ready                 : FIFO can accept a plot this cycle (!full)
//   fb_grant              : framebuffer write port available this cycle
//   fb_wren/address/data  : registered framebuffer write
//   idle                  : FIFO empty and no write in flight
//   drop_count/clip_count : saturating counts of dropped / clipped plots
// Optional build macro: PLOT_SINK_TRANSPARENT_KEY_EN discards on-screen
// plots whose colour equals TRANSPARENT_COLOR.
module plot_sink #(
  parameter int unsigned           COLOR_DEPTH       = plot_sink_pkg::COLOR_DEPTH,
  parameter int unsigned           SCREEN_W          = plot_sink_pkg::SCREEN_W,
  parameter int unsigned           SCREEN_H          = plot_sink_pkg::SCREEN_H,
  parameter int unsigned           FB_ADDR_W         = plot_sink_pkg::FB_ADDR_W,
  parameter int unsigned           FIFO_DEPTH        = 4,
  parameter logic [COLOR_DEPTH-1:0] TRANSPARENT_COLOR = '0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   plot,
  input  logic [7:0]             x,
  input  logic [6:0]             y,
  input  logic [COLOR_DEPTH-1:0] color,
  output logic                   ready,
  input  logic                   fb_grant,
  output logic                   fb_wren,
  output logic [FB_ADDR_W-1:0]   fb_address,
  output logic [COLOR_DEPTH-1:0] fb_data,
  output logic                   idle,
  output logic [7:0]             drop_count,
  output logic [7:0]             clip_count
);

  import plot_sink_pkg::*;

`ifdef PLOT_SINK_TRANSPARENT_KEY_EN
  localparam bit KEY_EN = 1'b1;
`else
  localparam bit KEY_EN = 1'b0;
`endif

  localparam int unsigned ENTRY_W = FB_ADDR_W + COLOR_DEPTH;

  drain_state_e state_q, state_d;

  logic                   fb_wren_q, fb_wren_d;
  logic [FB_ADDR_W-1:0]   fb_address_q, fb_address_d;
  logic [COLOR_DEPTH-1:0] fb_data_q, fb_data_d;
  logic [7:0]             drop_q, drop_d;
  logic [7:0]             clip_q, clip_d;

  logic [31:0]            lin_addr;
  logic                   on_screen, key_hit;
  logic                   push, pop, full, empty;
  logic [ENTRY_W-1:0]     wdata, rdata;

  assign ready     = !full;
  assign on_screen = (32'(x) < SCREEN_W) && (32'(y) < SCREEN_H);
  assign lin_addr  = 32'(y) * SCREEN_W + 32'(x);
  assign key_hit   = KEY_EN && (color == TRANSPARENT_COLOR);
  assign push      = plot && ready && on_screen && !key_hit;
  assign pop       = (state_q == S_DRAIN) && fb_grant && !empty;
  assign wdata     = {FB_ADDR_W'(lin_addr), color};

  pixel_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_d      = state_q;
    fb_wren_d    = pop;
    fb_address_d = fb_address_q;
    fb_data_d    = fb_data_q;
    drop_d       = drop_q;
    clip_d       = clip_q;

    // Without an occupancy count the FSM leaves S_DRAIN on the first cycle
    // it sees the FIFO empty with no push; pops only ever occur while
    // entries exist, so the write stream is unchanged.
    unique case (state_q)
      S_IDLE:  if (push) state_d = S_DRAIN;
      S_DRAIN: if (empty && !push) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      fb_address_d = rdata[ENTRY_W-1:COLOR_DEPTH];
      fb_data_d    = rdata[COLOR_DEPTH-1:0];
    end

    if (plot && !ready && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
    if (plot && ready && !on_screen && (clip_q != 8'hFF)) clip_d = clip_q + 8'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      fb_wren_q    <= 1'b0;
      fb_address_q <= '0;
      fb_data_q    <= '0;
      drop_q       <= '0;
      clip_q       <= '0;
    end else begin
      state_q      <= state_d;
      fb_wren_q    <= fb_wren_d;
      fb_address_q <= fb_address_d;
      fb_data_q    <= fb_data_d;
      drop_q       <= drop_d;
      clip_q       <= clip_d;
    end
  end

  assign fb_wren    = fb_wren_q;
  assign fb_address = fb_address_q;
  assign fb_data    = fb_data_q;
  assign drop_count = drop_q;
  assign clip_count = clip_q;
  assign idle       = empty && !fb_wren_q;

endmodule

// File: doc/plot_sink.md
Name: plot_sink

Overview:
- Receiving end of the pixel-plot interface driven by the background and tile drawers: takes `plot` / `x` / `y` / `color` strobes and writes them into the framebuffer RAM's single write port.
- Clips off-screen coordinates and converts (x, y) to a linear framebuffer address.
- Buffers requests in a small FIFO so drawer bursts survive cycles where the display scanner owns the RAM port (`fb_grant` low).
- Reports `idle` so a drawer can gate its own `done` on the frame actually landing in memory.

Parameters:
- COLOR_DEPTH, 9, bits per pixel colour.
- SCREEN_W, 160, visible width in pixels.
- SCREEN_H, 120, visible height in pixels.
- FB_ADDR_W, 15, framebuffer address width; must satisfy 2^FB_ADDR_W >= SCREEN_W*SCREEN_H.
- FIFO_DEPTH, 4, buffered plot entries; power of two, >= 2.
- TRANSPARENT_COLOR, 9'h000, colour key; used only with the optional feature.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- plot  in  1  pixel write request; valid for one cycle.
- x  in  8  pixel column.
- y  in  7  pixel row.
- color  in  COLOR_DEPTH  pixel colour.
- ready  out  1  high when the FIFO can accept a plot this cycle.
- fb_grant  in  1  framebuffer write port available to this block this cycle.
- fb_wren  out  1  framebuffer write enable; registered.
- fb_address  out  FB_ADDR_W  framebuffer write address; registered.
- fb_data  out  COLOR_DEPTH  framebuffer write data; registered.
- idle  out  1  FIFO empty and no write in flight.
- drop_count  out  8  saturating count of plots lost because `ready` was low.
- clip_count  out  8  saturating count of plots discarded as off-screen.

Behaviour:
- Reset (synchronous): FIFO emptied; `fb_wren`=0, `fb_address`=0, `fb_data`=0, `drop_count`=0, `clip_count`=0. During and after reset, `ready`=1 and `idle`=1.
  - Reset asserted mid-burst discards all buffered entries; no `fb_wren` pulse in the cycle after reset.
- `ready` = !full. It is combinational from registered FIFO state only, with no path from `plot` or `fb_grant`.
- Accept rule: at an edge where `plot`=1, a request is evaluated.
  - `ready`=0: request dropped; `drop_count` += 1 (saturates at 255); FIFO unchanged.
  - `ready`=1 and (x >= SCREEN_W or y >= SCREEN_H): discarded; `clip_count` += 1 (saturates at 255); no push. A clip takes precedence over nothing else, since it can only happen when `ready`=1.
  - `ready`=1 and on-screen: push {addr = y*SCREEN_W + x, color}. The multiply is computed at full width, then truncated to FB_ADDR_W.
- Drain FSM, two states:
  - S_IDLE: FIFO empty; `fb_wren` next = 0. Go to S_DRAIN when the FIFO becomes non-empty.
  - S_DRAIN: at each edge with `fb_grant`=1 and FIFO non-empty, pop the head; next cycle `fb_wren`=1 with the head's address and data.
  - S_DRAIN with `fb_grant`=0: no pop; `fb_wren` next = 0; `fb_address` and `fb_data` hold their previous values.
  - Return to S_IDLE when a pop empties the FIFO and no push happens in the same cycle.
- Latency: an on-screen plot into an empty FIFO with `fb_grant` held high gives `fb_wren`=1 exactly 2 cycles after the `plot` cycle (push edge, then pop edge).
- Throughput: one write per cycle while `fb_grant`=1.
- Simultaneous push and pop:
  - Allowed whenever `ready`=1; occupancy stays the same.
  - When full, push is refused even if a pop occurs that cycle.
- Ordering: writes reach the framebuffer strictly in accept order. Duplicate addresses are not merged; the last write wins.
- `idle` = FIFO empty and `fb_wren`=0.

Optional Feature:
- Macro PLOT_SINK_TRANSPARENT_KEY_EN.
- Defined: an accepted, on-screen plot with `color` == TRANSPARENT_COLOR is discarded without a push, and neither counter changes. This lets sprite tiles carry a see-through colour.
- Undefined: TRANSPARENT_COLOR is ignored; every on-screen plot is written.

Decomposition:
- Shared package (screen constants) holds SCREEN_W, SCREEN_H, FB_ADDR_W and COLOR_DEPTH, plus the drain-state encoding (S_IDLE=0, S_DRAIN=1). All drawers use the same package.
- One sub-module, `pixel_fifo`:
  - synchronous FIFO, width FB_ADDR_W+COLOR_DEPTH, depth FIFO_DEPTH;
  - ports push, pop, wdata, rdata, full, empty;
  - first-word-fall-through.
- `plot_sink` holds the clip and address logic, the counters and the drain FSM.

Test Plan:
- Reset, then plot x=3, y=2, color=9'h1A5 with `fb_grant`=1 -> 2 cycles later `fb_wren`=1, `fb_address`=323, `fb_data`=9'h1A5 for 1 cycle; `idle` returns to 1 on the following cycle.
- Plot (160,0), (0,120) and (255,127) -> no `fb_wren` ever; `clip_count`=3; `idle` stays 1.
- `fb_grant`=0, then 6 consecutive on-screen plots with FIFO_DEPTH=4 -> `ready` falls after the 4th; `drop_count`=2. Raise `fb_grant` -> exactly 4 writes, in order, on back-to-back cycles.
- `fb_grant` toggling 1,0,1,0 during a 3-pixel burst -> `fb_wren` pulses only on cycles following grant-high pops; addresses are in order; no write is lost or duplicated.
- Assert `reset` for 1 cycle with 3 entries buffered -> no further `fb_wren`; counters read 0; `ready`=1; `idle`=1.
- With PLOT_SINK_TRANSPARENT_KEY_EN defined, plot color=9'h000 then 9'h0FF at (5,5) -> a single write, `fb_address`=805, `fb_data`=9'h0FF.
